// File: rtl/vector_divide_control.sv
// Control FSM for the vector-divide datapath: walks Ndata (X,Y) pairs in RAM,
// runs the divider on each pair and writes quotient/rest back in place.
`timescale 1ns/1ps

module vector_divide_control #(
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6,
  parameter int RAM_SIZE   = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stopvd,
  output logic [2:0]          control_Addr,
  output logic                LoadX_reg,
  output logic                LoadY_reg,
  output logic                start_div,
  output logic                stop_div,
  output logic                Wdata_control,
  output logic                We,
  output logic                busy,
  output logic                done,
  output logic [RAM_SIZE-1:0] pairs_done
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CHECK = 4'd1,
    S_LDX   = 4'd2,
    S_LDY   = 4'd3,
    S_START = 4'd4,
    S_WAIT  = 4'd5,
    S_WRQ   = 4'd6,
    S_WRR   = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  localparam logic [2:0] ADDR_RESET = 3'd0;
  localparam logic [2:0] ADDR_INC   = 3'd1;
  localparam logic [2:0] ADDR_DEC   = 3'd3;
  localparam logic [2:0] ADDR_HOLD  = 3'd4;

  // Counting down from DIV_CYCLES-1 to 0 keeps S_WAIT exactly DIV_CYCLES long.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == S_START) begin
      wait_cnt <= WAIT_LOAD;
    end else if (state == S_WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pairs_done <= '0;
    end else if (state == S_IDLE && start) begin
      pairs_done <= '0;
    end else if (state == S_WRR) begin
      pairs_done <= pairs_done + RAM_SIZE'(1);
    end
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:  state_next = start ? S_CHECK : S_IDLE;
      S_CHECK: state_next = stopvd ? S_DONE : S_LDX;
      S_LDX:   state_next = S_LDY;
      S_LDY:   state_next = S_START;
      S_START: state_next = S_WAIT;
      S_WAIT:  state_next = (wait_cnt == '0) ? S_WRQ : S_WAIT;
      S_WRQ:   state_next = S_WRR;
      S_WRR:   state_next = S_CHECK;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Unknown encodings drive the idle decode until the next edge recovers the FSM.
  always_comb begin
    control_Addr  = ADDR_HOLD;
    LoadX_reg     = 1'b0;
    LoadY_reg     = 1'b0;
    start_div     = 1'b0;
    stop_div      = 1'b0;
    Wdata_control = 1'b0;
    We            = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        control_Addr = ADDR_RESET;
        busy         = 1'b0;
      end
      S_CHECK: control_Addr = ADDR_HOLD;
      S_LDX: begin
        LoadX_reg    = 1'b1;
        control_Addr = ADDR_INC;
      end
      S_LDY: begin
        LoadY_reg    = 1'b1;
        control_Addr = ADDR_DEC;
      end
      S_START: start_div = 1'b1;
      S_WAIT:  control_Addr = ADDR_HOLD;
      S_WRQ: begin
        We            = 1'b1;
        Wdata_control = 1'b1;
        stop_div      = 1'b1;
        control_Addr  = ADDR_INC;
      end
      S_WRR: begin
        We            = 1'b1;
        Wdata_control = 1'b0;
        stop_div      = 1'b1;
        control_Addr  = ADDR_INC;
      end
      S_DONE: done = 1'b1;
      default: begin
        control_Addr = ADDR_RESET;
        busy         = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vector_divide_control.sv
// Bench for vector_divide_control: models the RAM, address register and a
// fixed-latency divider, and scoreboards every write-back against expectations.
`timescale 1ns/1ps

module tb_vector_divide_control;

  localparam int DIV_CYCLES = 33;
  localparam int RAM_SIZE   = 10;

  logic                clock = 1'b0;
  logic                reset;
  logic                start;
  logic                stopvd;
  logic [2:0]          control_Addr;
  logic                LoadX_reg;
  logic                LoadY_reg;
  logic                start_div;
  logic                stop_div;
  logic                Wdata_control;
  logic                We;
  logic                busy;
  logic                done;
  logic [RAM_SIZE-1:0] pairs_done;

  vector_divide_control #(
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W(6),
    .RAM_SIZE(RAM_SIZE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .stopvd(stopvd),
    .control_Addr(control_Addr),
    .LoadX_reg(LoadX_reg),
    .LoadY_reg(LoadY_reg),
    .start_div(start_div),
    .stop_div(stop_div),
    .Wdata_control(Wdata_control),
    .We(We),
    .busy(busy),
    .done(done),
    .pairs_done(pairs_done)
  );

  always #5 clock = ~clock;

  // Datapath model: address register, combinational-read RAM, operand registers
  // and a divider whose result is only valid DIV_CYCLES edges after start_div.
  logic [15:0] mem [0:15];
  logic [15:0] init_mem [0:15];
  logic        load_mem = 1'b0;
  logic [7:0]  addr = 8'd0;
  logic [15:0] reg_x = 16'd0;
  logic [15:0] reg_y = 16'd1;
  logic [15:0] quo = 16'd0;
  logic [15:0] rem = 16'd0;
  int          div_cnt = 0;
  logic        div_armed = 1'b0;
  int          ndata = 0;
  logic [15:0] wdata;

  assign stopvd = (addr == 8'(2 * ndata));
  assign wdata  = (div_armed && div_cnt == 0) ? (Wdata_control ? quo : rem) : 16'hDEAD;

  always @(posedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
    end else if (We) begin
      mem[addr[3:0]] <= wdata;
    end
    if (LoadX_reg) reg_x <= mem[addr[3:0]];
    if (LoadY_reg) reg_y <= mem[addr[3:0]];
    if (start_div) begin
      quo       <= reg_x / reg_y;
      rem       <= reg_x % reg_y;
      div_cnt   <= DIV_CYCLES;
      div_armed <= 1'b1;
    end else if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
    end
    case (control_Addr)
      3'd0:    addr <= 8'd0;
      3'd1:    addr <= addr + 8'd1;
      3'd2:    addr <= addr + 8'd2;
      3'd3:    addr <= addr - 8'd1;
      default: addr <= addr;
    endcase
  end

  typedef struct {
    logic [7:0]  waddr;
    logic        ctl;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];

  int check_cnt = 0;
  int pass_cnt  = 0;

  int  r_first_done;
  int  r_last_done;
  int  r_dones;
  int  r_writes;
  int  r_loads;
  int  r_sdivs;
  int  r_idles;
  bit  r_timed_out;

  task automatic set_mem(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    for (int i = 0; i < 16; i++) init_mem[i] = 16'd0;
    init_mem[0] = a;
    init_mem[1] = b;
    init_mem[2] = c;
    init_mem[3] = d;
    @(negedge clock);
    load_mem = 1'b1;
    @(negedge clock);
    load_mem = 1'b0;
  endtask

  task automatic push_write(input logic [7:0] a, input logic c, input logic [15:0] d);
    wr_t e;
    e.waddr = a;
    e.ctl   = c;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // Pulses (or holds) start, then walks cycle by cycle from cycle 1 (S_CHECK),
  // popping the scoreboard on every write strobe. Stops after n_done done pulses
  // or right after processing cycle stop_at.
  task automatic run(input int repulse_at, input int stop_at, input bit hold, input int n_done);
    int cyc;
    wr_t e;
    r_first_done = 0;
    r_last_done  = 0;
    r_dones      = 0;
    r_writes     = 0;
    r_loads      = 0;
    r_sdivs      = 0;
    r_idles      = 0;
    r_timed_out  = 1'b1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    if (!hold) start = 1'b0;
    cyc = 1;
    for (int k = 0; k < 400; k++) begin
      if (done) begin
        r_dones++;
        if (r_dones == 1) r_first_done = cyc;
        r_last_done = cyc;
      end
      if (!busy) r_idles++;
      if (LoadX_reg || LoadY_reg) r_loads++;
      if (start_div) r_sdivs++;
      if (We) begin
        r_writes++;
        check_cnt++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL write_unexpected: cycle %0d got addr=%0d ctl=%0b data=%0d, required no write",
                   cyc, addr, Wdata_control, wdata);
        end else begin
          e = exp_q.pop_front();
          if (addr !== e.waddr || Wdata_control !== e.ctl || wdata !== e.data || LoadX_reg || LoadY_reg)
            $display("[TB] FAIL write_back: cycle %0d got addr=%0d ctl=%0b data=%0d load=%0b, required addr=%0d ctl=%0b data=%0d load=0",
                     cyc, addr, Wdata_control, wdata, LoadX_reg | LoadY_reg, e.waddr, e.ctl, e.data);
          else
            pass_cnt++;
        end
      end
      if ((stop_at != 0 && cyc == stop_at) || (r_dones == n_done && n_done != 0)) begin
        r_timed_out = 1'b0;
        break;
      end
      if (!hold) start = (cyc == repulse_at);
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    check_cnt++;
    if (r_timed_out)
      $display("[TB] FAIL run_timeout: got %0d done pulses, required %0d within budget", r_dones, n_done);
    else
      pass_cnt++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    #1;
    check_cnt++;
    if ({control_Addr, LoadX_reg, LoadY_reg, start_div, stop_div, Wdata_control, We, busy, done} !== 11'b0)
      $display("[TB] FAIL reset_outputs: got addr=%0d ldx=%0b ldy=%0b sd=%0b st=%0b wc=%0b we=%0b busy=%0b done=%0b, required all 0",
               control_Addr, LoadX_reg, LoadY_reg, start_div, stop_div, Wdata_control, We, busy, done);
    else
      pass_cnt++;
    check_cnt++;
    if (pairs_done !== '0)
      $display("[TB] FAIL reset_pairs_done: got %0d, required 0", pairs_done);
    else
      pass_cnt++;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_pair;
    ndata = 1;
    set_mem(16'd100, 16'd7, 16'd0, 16'd0);
    push_write(8'd0, 1'b1, 16'd14);
    push_write(8'd1, 1'b0, 16'd2);
    run(0, 0, 1'b0, 1);
    check_cnt++;
    if (r_first_done !== 41) $display("[TB] FAIL single_done_cycle: got %0d, required 41", r_first_done);
    else pass_cnt++;
    check_cnt++;
    if (pairs_done !== 10'd1) $display("[TB] FAIL single_pairs_done: got %0d, required 1", pairs_done);
    else pass_cnt++;
    @(negedge clock);
    check_cnt++;
    if (mem[0] !== 16'd14 || mem[1] !== 16'd2)
      $display("[TB] FAIL single_mem: got %0d,%0d, required 14,2", mem[0], mem[1]);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || exp_q.size() != 0)
      $display("[TB] FAIL single_idle_after: got busy=%0b done=%0b pending=%0d, required 0,0,0", busy, done, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_two_pairs;
    ndata = 2;
    set_mem(16'd100, 16'd7, 16'd9, 16'd3);
    push_write(8'd0, 1'b1, 16'd14);
    push_write(8'd1, 1'b0, 16'd2);
    push_write(8'd2, 1'b1, 16'd3);
    push_write(8'd3, 1'b0, 16'd0);
    run(0, 0, 1'b0, 1);
    check_cnt++;
    if (r_first_done !== 80) $display("[TB] FAIL two_done_cycle: got %0d, required 80", r_first_done);
    else pass_cnt++;
    check_cnt++;
    if (r_writes !== 4 || r_loads !== 4 || r_sdivs !== 2)
      $display("[TB] FAIL two_pulse_counts: got we=%0d load=%0d sdiv=%0d, required 4,4,2", r_writes, r_loads, r_sdivs);
    else pass_cnt++;
    check_cnt++;
    if (pairs_done !== 10'd2) $display("[TB] FAIL two_pairs_done: got %0d, required 2", pairs_done);
    else pass_cnt++;
    @(negedge clock);
    check_cnt++;
    if (mem[0] !== 16'd14 || mem[1] !== 16'd2 || mem[2] !== 16'd3 || mem[3] !== 16'd0)
      $display("[TB] FAIL two_mem: got %0d,%0d,%0d,%0d, required 14,2,3,0", mem[0], mem[1], mem[2], mem[3]);
    else pass_cnt++;
  endtask

  task automatic test_empty_run;
    ndata = 0;
    run(0, 0, 1'b0, 1);
    check_cnt++;
    if (r_first_done !== 2) $display("[TB] FAIL empty_done_cycle: got %0d, required 2", r_first_done);
    else pass_cnt++;
    check_cnt++;
    if (r_writes !== 0 || r_loads !== 0 || r_sdivs !== 0)
      $display("[TB] FAIL empty_pulses: got we=%0d load=%0d sdiv=%0d, required 0,0,0", r_writes, r_loads, r_sdivs);
    else pass_cnt++;
    check_cnt++;
    if (pairs_done !== 10'd0) $display("[TB] FAIL empty_pairs_done: got %0d, required 0", pairs_done);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy;
    int extra_done;
    ndata = 1;
    set_mem(16'd100, 16'd7, 16'd0, 16'd0);
    push_write(8'd0, 1'b1, 16'd14);
    push_write(8'd1, 1'b0, 16'd2);
    run(20, 0, 1'b0, 1);
    check_cnt++;
    if (r_first_done !== 41) $display("[TB] FAIL busy_start_done_cycle: got %0d, required 41", r_first_done);
    else pass_cnt++;
    extra_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (done || busy) extra_done++;
    end
    check_cnt++;
    if (extra_done !== 0) $display("[TB] FAIL busy_start_ignored: got %0d active cycles after done, required 0", extra_done);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    ndata = 2;
    set_mem(16'd100, 16'd7, 16'd9, 16'd3);
    push_write(8'd0, 1'b1, 16'd14);
    push_write(8'd1, 1'b0, 16'd2);
    push_write(8'd2, 1'b1, 16'd3);
    run(0, 77, 1'b0, 0);
    @(posedge clock);
    #2;
    check_cnt++;
    if (We !== 1'b1 || Wdata_control !== 1'b0 || addr !== 8'd3)
      $display("[TB] FAIL midrun_in_wrr: got we=%0b wc=%0b addr=%0d, required 1,0,3", We, Wdata_control, addr);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    check_cnt++;
    if (busy !== 1'b0 || We !== 1'b0 || done !== 1'b0 || control_Addr !== 3'd0 || stop_div !== 1'b0)
      $display("[TB] FAIL midrun_async_idle: got busy=%0b we=%0b done=%0b addr_cmd=%0d stop=%0b, required 0,0,0,0,0",
               busy, We, done, control_Addr, stop_div);
    else pass_cnt++;
    repeat (2) @(negedge clock);
    check_cnt++;
    if (mem[2] !== 16'd3 || mem[3] !== 16'd3 || exp_q.size() != 0)
      $display("[TB] FAIL midrun_mem: got mem2=%0d mem3=%0d pending=%0d, required 3,3,0", mem[2], mem[3], exp_q.size());
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clock);
    push_write(8'd0, 1'b1, 16'd7);
    push_write(8'd1, 1'b0, 16'd0);
    push_write(8'd2, 1'b1, 16'd1);
    push_write(8'd3, 1'b0, 16'd0);
    run(0, 0, 1'b0, 1);
    check_cnt++;
    if (r_first_done !== 80 || pairs_done !== 10'd2)
      $display("[TB] FAIL midrun_rerun: got done_cycle=%0d pairs=%0d, required 80,2", r_first_done, pairs_done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    ndata = 1;
    set_mem(16'd100, 16'd7, 16'd0, 16'd0);
    push_write(8'd0, 1'b1, 16'd14);
    push_write(8'd1, 1'b0, 16'd2);
    push_write(8'd0, 1'b1, 16'd7);
    push_write(8'd1, 1'b0, 16'd0);
    run(0, 0, 1'b1, 2);
    check_cnt++;
    if (r_first_done !== 41 || r_last_done !== 83)
      $display("[TB] FAIL b2b_done_cycles: got %0d,%0d, required 41,83", r_first_done, r_last_done);
    else pass_cnt++;
    check_cnt++;
    if (r_idles !== 1) $display("[TB] FAIL b2b_idle_gap: got %0d idle cycles, required 1", r_idles);
    else pass_cnt++;
    @(negedge clock);
    @(negedge clock);
    check_cnt++;
    if (busy !== 1'b0 || exp_q.size() != 0 || mem[0] !== 16'd7 || mem[1] !== 16'd0)
      $display("[TB] FAIL b2b_final: got busy=%0b pending=%0d mem=%0d,%0d, required 0,0,7,0",
               busy, exp_q.size(), mem[0], mem[1]);
    else pass_cnt++;
  endtask

  initial begin
    $display("[TB] starting vector_divide_control bench");
    test_reset();
    test_single_pair();
    test_two_pairs();
    test_empty_run();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
